// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the ram_flip scratch-RAM arbiter.
//   - default RAM geometry (16 x 8)
//   - port identifiers used to index request/grant vectors ([0]=A, [1]=B)
//   - sequencer state encoding
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: bundle of the two requester ports and the ram_flip control bus.
//   a_*/b_* : req/we/adrs/wdata from requesters, gnt/ack/rdata back to them
//   ram_*   : enable/read/adrs/data_in to the RAM, data_out from the RAM
// Modports:
//   slave  - the arbiter (consumes requests, drives the RAM)
//   master - the surrounding logic (requesters and RAM)
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_adrs;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_adrs;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_enable;
  logic              ram_read;
  logic [ADDR_W-1:0] ram_adrs;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_adrs, a_wdata,
    output a_gnt, a_ack, a_rdata,
    input  b_req, b_we, b_adrs, b_wdata,
    output b_gnt, b_ack, b_rdata,
    output ram_enable, ram_read, ram_adrs, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output a_req, a_we, a_adrs, a_wdata,
    input  a_gnt, a_ack, a_rdata,
    output b_req, b_we, b_adrs, b_wdata,
    input  b_gnt, b_ack, b_rdata,
    input  ram_enable, ram_read, ram_adrs, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick.
//   req [1:0] in  : request pair, indexed by PORT_A / PORT_B
//   ptr       in  : port that wins a tie
//   gnt [1:0] out : one-hot winner, all-zero when nothing is requested
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt         = 2'b00;
      gnt[ptr]    = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter/sequencer sharing the 16x8 ram_flip RAM
// between the SPI engine (port A) and the host logic (port B).
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   a_lock     : (RAM_ARB_LOCK_EN builds only) A holds the RAM across
//                back-to-back transactions while high
//   bus        : ram_arb_if.slave - requester handshakes and RAM controls
// Optional feature macro: RAM_ARB_LOCK_EN
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for req; winner's operands latched on leaving
// ST_ACCESS | RAM enabled for one cycle with latched operands
// ST_RESP   | ack to owner, read data taken from RAM, pointer advanced
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic    clk,
  input  logic    rst,
`ifdef RAM_ARB_LOCK_EN
  input  logic    a_lock,
`endif
  ram_arb_if.slave bus
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
`ifdef RAM_ARB_LOCK_EN
  logic              lock_q, lock_d;
`endif

  logic [1:0]        req_vec;
  logic [1:0]        win;
  logic              b_req_eff;
  logic [DATA_W-1:0] resp_data;

  // A locked burst in progress hides B from the picker entirely.
  always_comb begin
    b_req_eff = bus.b_req;
`ifdef RAM_ARB_LOCK_EN
    if (a_lock && bus.a_req) begin
      b_req_eff = 1'b0;
    end
`endif
  end

  assign req_vec = {b_req_eff, bus.a_req};

  rr_arb2 u_rr_arb2 (
    .req (req_vec),
    .ptr (ptr_q),
    .gnt (win)
  );

  // Writes return zero so a stale RAM output never leaks to the requester.
  assign resp_data = we_q ? '0 : bus.ram_data_out;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    adrs_d      = adrs_q;
    wdata_d     = wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
`ifdef RAM_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    bus.ram_enable = 1'b0;
    bus.ram_read   = 1'b0;
    bus.a_gnt      = 1'b0;
    bus.b_gnt      = 1'b0;
    bus.a_ack      = 1'b0;
    bus.b_ack      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win[PORT_A] || win[PORT_B]) begin
          state_d = ST_ACCESS;
          if (win[PORT_B]) begin
            owner_d = PORT_B;
            we_d    = bus.b_we;
            adrs_d  = bus.b_adrs;
            wdata_d = bus.b_wdata;
          end else begin
            owner_d = PORT_A;
            we_d    = bus.a_we;
            adrs_d  = bus.a_adrs;
            wdata_d = bus.a_wdata;
          end
`ifdef RAM_ARB_LOCK_EN
          lock_d = win[PORT_A] & a_lock;
`endif
        end
      end

      ST_ACCESS: begin
        bus.ram_enable = 1'b1;
        bus.ram_read   = ~we_q;
        bus.a_gnt      = (owner_q == PORT_A);
        bus.b_gnt      = (owner_q == PORT_B);
        state_d        = ST_RESP;
      end

      ST_RESP: begin
        bus.a_gnt = (owner_q == PORT_A);
        bus.b_gnt = (owner_q == PORT_B);
        bus.a_ack = (owner_q == PORT_A);
        bus.b_ack = (owner_q == PORT_B);
        if (owner_q == PORT_A) begin
          a_rdata_d = resp_data;
        end else begin
          b_rdata_d = resp_data;
        end
        ptr_d = ~owner_q;
`ifdef RAM_ARB_LOCK_EN
        if (lock_q) begin
          ptr_d = PORT_A;
        end
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // rdata is visible combinationally during the ack cycle and held after.
  assign bus.a_rdata     = a_rdata_d;
  assign bus.b_rdata     = b_rdata_d;
  assign bus.ram_adrs    = adrs_q;
  assign bus.ram_data_in = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PORT_A;
      owner_q   <= PORT_A;
      we_q      <= 1'b0;
      adrs_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef RAM_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      adrs_q    <= adrs_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef RAM_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized + directed bench for ram_arbiter with a
// transaction-level reference model and an ack-driven scoreboard.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    logic       we;
    logic [3:0] adrs;
    logic [7:0] wdata;
    logic       lock;
  } op_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [3:0] adrs;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef RAM_ARB_LOCK_EN
  logic a_lock = 1'b0;
`endif

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   sb_en  = 1'b0;

  op_t  qa[$];
  op_t  qb[$];
  exp_t sb[$];

  logic [7:0] m_mem   [16];
  logic       m_ptr;
  logic [7:0] ram_mem [16];

  logic [7:0] last_a, last_b;
  int         en_cnt;
  exp_t       h;

  ram_arb_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef RAM_ARB_LOCK_EN
    .a_lock (a_lock),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data appears the cycle after the enabled cycle.
  always @(posedge clk) begin
    if (bus.ram_enable) begin
      if (bus.ram_read) bus.ram_data_out <= ram_mem[bus.ram_adrs];
      else              ram_mem[bus.ram_adrs] <= bus.ram_data_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic we, input logic [3:0] adrs,
                             input logic [7:0] wdata, input logic lock);
    op_t o;
    o.we = we; o.adrs = adrs; o.wdata = wdata; o.lock = lock;
    return o;
  endfunction

  // Transaction-level model: while both ports have pending work the tie
  // goes to the pointer side, one transaction completes every 3 cycles.
  task automatic predict(input int c0);
    int   ia, ib, k;
    logic pa, pb, w;
    op_t  op;
    exp_t e;
    ia = 0; ib = 0; k = 0;
    while (ia < qa.size() || ib < qb.size()) begin
      pa = (ia < qa.size());
      pb = (ib < qb.size());
      if (pa && qa[ia].lock) pb = 1'b0;
      if (pa && pb) w = m_ptr;
      else          w = pb ? PORT_B : PORT_A;
      if (w == PORT_B) begin op = qb[ib]; ib++; end
      else             begin op = qa[ia]; ia++; end
      e.port  = w;
      e.we    = op.we;
      e.adrs  = op.adrs;
      e.wdata = op.wdata;
      e.rdata = op.we ? 8'h00 : m_mem[op.adrs];
      if (op.we) m_mem[op.adrs] = op.wdata;
      e.cyc   = c0 + 2 + 3 * k;
      k++;
      m_ptr = (w == PORT_A && op.lock) ? PORT_A : ~w;
      sb.push_back(e);
    end
  endtask

  task automatic present();
    if (qa.size() > 0) begin
      bus.a_req = 1'b1; bus.a_we = qa[0].we; bus.a_adrs = qa[0].adrs; bus.a_wdata = qa[0].wdata;
`ifdef RAM_ARB_LOCK_EN
      a_lock = qa[0].lock;
`endif
    end else begin
      bus.a_req = 1'b0;
`ifdef RAM_ARB_LOCK_EN
      a_lock = 1'b0;
`endif
    end
    if (qb.size() > 0) begin
      bus.b_req = 1'b1; bus.b_we = qb[0].we; bus.b_adrs = qb[0].adrs; bus.b_wdata = qb[0].wdata;
    end else begin
      bus.b_req = 1'b0;
    end
  endtask

  task automatic run_phase();
    int c0, guard;
    @(posedge clk); #1;
    c0 = cyc;
    predict(c0);
    present();
    guard = 3 * (qa.size() + qb.size()) + 10;
    while ((qa.size() > 0 || qb.size() > 0) && guard > 0) begin
      @(posedge clk); #1;
      guard--;
      if (bus.a_ack && qa.size() > 0) void'(qa.pop_front());
      if (bus.b_ack && qb.size() > 0) void'(qb.pop_front());
      present();
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      check("phase_timeout", 1, 0);
      qa.delete(); qb.delete();
      present();
    end
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: compares the DUT against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (rst) begin
      last_a = 8'h00; last_b = 8'h00; en_cnt = 0;
    end else if (sb_en) begin
      check("gnt_exclusive", bus.a_gnt & bus.b_gnt, 0);
      check("ack_exclusive", bus.a_ack & bus.b_ack, 0);
      if (bus.ram_enable) begin
        en_cnt++;
        if (sb.size() == 0) check("unexpected_access", 1, 0);
        else begin
          h = sb[0];
          check("ram_read", bus.ram_read, !h.we);
          check("ram_adrs", bus.ram_adrs, h.adrs);
          check("ram_data_in", bus.ram_data_in, h.wdata);
          check("a_gnt_access", bus.a_gnt, h.port == PORT_A);
          check("b_gnt_access", bus.b_gnt, h.port == PORT_B);
        end
      end else if (bus.a_ack || bus.b_ack) begin
        if (sb.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          h = sb.pop_front();
          check("ack_port", bus.b_ack, h.port);
          check("ack_cycle", cyc, h.cyc);
          check("enable_cycles", en_cnt, 1);
          check("a_gnt_resp", bus.a_gnt, h.port == PORT_A);
          check("b_gnt_resp", bus.b_gnt, h.port == PORT_B);
          if (h.port == PORT_A) begin
            check("a_rdata", bus.a_rdata, h.rdata);
            check("b_rdata_hold", bus.b_rdata, last_b);
            last_a = h.rdata;
          end else begin
            check("b_rdata", bus.b_rdata, h.rdata);
            check("a_rdata_hold", bus.a_rdata, last_a);
            last_b = h.rdata;
          end
        end
        en_cnt = 0;
      end else begin
        check("a_gnt_idle", bus.a_gnt, 0);
        check("b_gnt_idle", bus.b_gnt, 0);
        check("a_rdata_hold", bus.a_rdata, last_a);
        check("b_rdata_hold", bus.b_rdata, last_b);
      end
    end
  end

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_adrs = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_adrs = '0; bus.b_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i]   = 8'h00;
      ram_mem[i] = 8'h00;
    end
    m_ptr = PORT_A;

    repeat (2) @(posedge clk);
    #1;
    check("rst_a_gnt", bus.a_gnt, 0);
    check("rst_a_ack", bus.a_ack, 0);
    check("rst_a_rdata", bus.a_rdata, 0);
    check("rst_b_gnt", bus.b_gnt, 0);
    check("rst_b_ack", bus.b_ack, 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    check("rst_ram_enable", bus.ram_enable, 0);
    check("rst_ram_read", bus.ram_read, 0);
    check("rst_ram_adrs", bus.ram_adrs, 0);
    check("rst_ram_data_in", bus.ram_data_in, 0);
    @(negedge clk);
    rst = 1'b0;
    sb_en = 1'b1;

    // A writes 45 to address 2, then B reads it back.
    qa.push_back(mk(1'b1, 4'd2, 8'd45, 1'b0));
    run_phase();
    qb.push_back(mk(1'b0, 4'd2, 8'h00, 1'b0));
    run_phase();

    // Contention: 4 transactions per port, A writes what B later reads.
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b1, 4'(8 + i), 8'($urandom), 1'b0));
      qb.push_back(mk(1'b0, 4'(8 + i), 8'($urandom), 1'b0));
    end
    run_phase();

    // B alone: back-to-back writes then read-back.
    for (int i = 0; i < 8; i++) qb.push_back(mk(1'b1, 4'(i), 8'(8'hA0 + i), 1'b0));
    for (int i = 0; i < 8; i++) qb.push_back(mk(1'b0, 4'(i), 8'h00, 1'b0));
    run_phase();

    // A holds req across acks with the address changing 2 -> 3.
    qa.push_back(mk(1'b1, 4'd2, 8'h11, 1'b0));
    qa.push_back(mk(1'b1, 4'd3, 8'h22, 1'b0));
    qa.push_back(mk(1'b0, 4'd3, 8'h00, 1'b0));
    qa.push_back(mk(1'b0, 4'd2, 8'h00, 1'b0));
    run_phase();

    // Reset during the ACCESS cycle of an A write to address 5.
    sb_en = 1'b0;
    @(posedge clk); #1;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_adrs = 4'd5; bus.a_wdata = 8'h5A;
    @(posedge clk); #1;
    check("mid_access_enable", bus.ram_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_enable", bus.ram_enable, 0);
    check("mid_rst_read", bus.ram_read, 0);
    check("mid_rst_a_gnt", bus.a_gnt, 0);
    check("mid_rst_adrs", bus.ram_adrs, 0);
    check("mid_rst_data_in", bus.ram_data_in, 0);
    bus.a_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    m_ptr = PORT_A;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_ack", bus.a_ack, 0);
    end
    sb_en = 1'b1;

    // Simultaneous requests after reset: A must go first.
    qa.push_back(mk(1'b0, 4'd5, 8'h00, 1'b0));
    qb.push_back(mk(1'b0, 4'd2, 8'h00, 1'b0));
    run_phase();

`ifdef RAM_ARB_LOCK_EN
    // Locked A burst of 3 reads while B is requesting throughout.
    for (int i = 0; i < 3; i++) qa.push_back(mk(1'b0, 4'(8 + i), 8'h00, 1'b1));
    qb.push_back(mk(1'b0, 4'd0, 8'h00, 1'b0));
    run_phase();
`endif

    for (int p = 0; p < 12; p++) begin
      int na, nb;
      logic lk;
      na = $urandom_range(0, 5);
      nb = $urandom_range(0, 5);
      for (int i = 0; i < na; i++) begin
        lk = 1'b0;
`ifdef RAM_ARB_LOCK_EN
        lk = 1'($urandom_range(0, 1));
`endif
        qa.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), lk));
      end
      for (int i = 0; i < nb; i++)
        qb.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'b0));
      run_phase();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the shared 16x8 `ram_flip` scratch RAM.
- Shares the RAM between the SPI engine (port A) and the local host logic (port B).
- Per transaction it latches the winner's operands, drives the RAM `enable`/`read`/`adrs`/`data_in` controls for one cycle, then returns read data with an ack pulse.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A transaction request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_adrs  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A currently owns the RAM (ACCESS and RESP states).
- a_ack  out  1  one-cycle completion pulse to port A.
- a_rdata  out  DATA_W  port A read data; valid while a_ack=1.
- b_req, b_we, b_adrs, b_wdata, b_gnt, b_ack, b_rdata: same as port A, for port B.
- ram_enable  out  1  RAM enable, high only in ACCESS.
- ram_read  out  1  RAM read select (equals ~we of the winner), valid in ACCESS.
- ram_adrs  out  ADDR_W  latched winner address.
- ram_data_in  out  DATA_W  latched winner write data.
- ram_data_out  in  DATA_W  RAM read data; valid on the cycle after the ACCESS cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE, priority pointer=A, and all outputs 0. This covers gnt, ack, rdata, ram_enable, ram_read, ram_adrs and ram_data_in. Any in-flight transaction is dropped with no ack, and ram_enable falls immediately.
- FSM states:
  - IDLE: if any req is high, pick the winner, latch its we/adrs/wdata, set the owner, go to ACCESS; otherwise stay in IDLE.
  - ACCESS: ram_enable=1, ram_read=~we_q, owner gnt=1; go to RESP unconditionally.
  - RESP: owner gnt=1, owner ack=1 for this one cycle. On a read, rdata = ram_data_out captured this cycle; on a write, rdata is 0. Toggle the priority pointer to the non-owner, go to IDLE.
- Arbitration: only one req high → that port wins. Both high → the pointer side wins.
  - Pointer moves to the loser after every completed transaction, so simultaneous requests strictly alternate A, B, A, B.
- Latency: req sampled in IDLE → ack two cycles later. Throughput is one transaction per 3 cycles.
- Handshake rules:
  - Requester holds req, we, adrs and wdata stable from assertion through the ack cycle.
  - Requester drops req on the edge at which it samples ack=1, so req is already low in the following IDLE cycle.
  - A requester that keeps req high after ack starts a new transaction.
- Operand changes while the port is not owned are ignored; operands are latched only in IDLE.
- gnt and ack are never asserted for both ports in the same cycle. The non-owner outputs stay 0.
- rdata holds its value after ack until that port's next RESP.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- With the macro defined: adds input port a_lock (1 bit). If a_lock=1 when A wins in IDLE, the pointer is not moved to B after RESP, and B is refused in IDLE while a_lock=1 and a_req=1. This gives the SPI engine atomic multi-byte bursts. Releasing a_lock restores normal round-robin.
- Without the macro: no a_lock port; pure round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - default ADDR_W/DATA_W;
  - port-ID constants PORT_A=1'b0, PORT_B=1'b1.
- One sub-module, rr_arb2: 2-way round-robin pick from the req pair plus pointer, outputting a one-hot winner. The pointer register stays in ram_arbiter.

Test Plan:
- A write then B read: A writes adrs=2, wdata=45. Expect ram_enable=1, ram_read=0, ram_adrs=2, ram_data_in=45 for exactly one cycle, and a_ack 2 cycles after req. B then reads adrs=2: b_ack with b_rdata=45.
- Contention: a_req and b_req held high for 4 transactions each. Expect grant order A, B, A, B…, one ack every 3 cycles, and never both gnt high.
- Single requester back-to-back: B writes 8 addresses 0..7 with data 8'hA0+i while A is idle. Expect every B request served in 3 cycles, and a read-back of all 8 to match.
- Reset mid-ACCESS: assert rst during the ACCESS cycle of an A write to adrs=5. Expect ram_enable=0 immediately and no a_ack. After release: state IDLE and pointer=A, so simultaneous requests are granted to A first.
- Hold after ack: A keeps req high after ack with adrs changed 2→3. Expect a second transaction on adrs 3 that is properly latched.
- RAM_ARB_LOCK_EN build: a_lock=1 with 3 A reads while b_req is high throughout. Expect 3 consecutive A grants, then B granted only after a_lock=0.
